// File: rtl/dig_input_conditioner.sv
// dig_input_conditioner
//
// Front end for the DigCt logic stage. Each raw, asynchronous input line is
// synchronised into the CLK domain and then debounced. A new level is only
// accepted after it has been held for DEB_CYCLES consecutive clock edges.
// Every accepted transition produces a one-cycle RISE or FALL pulse.
//
// Build option:
//   DIG_COND_SYNC3_EN - when defined, a third synchroniser stage is added.
//                       All latencies then grow by one edge.
//
// Parameters:
//   WIDTH      - number of conditioned lines (bit i drives DigCt IN(i+1))
//   DEB_CYCLES - edges a new level must persist before acceptance (2..255)
//   RESET_VAL  - reset value of the sync stages and COND_OUT
//
// Ports:
//   CLK      in   rising-edge clock, shared with DigCt
//   RST_N    in   asynchronous active-low reset
//   RAW_IN   in   raw lines, asynchronous to CLK
//   HOLD     in   freezes counters, COND_OUT and STABLE; the sync stages
//                 keep sampling
//   COND_OUT out  debounced, registered levels
//   RISE     out  one-cycle pulse on an accepted 0->1 transition
//   FALL     out  one-cycle pulse on an accepted 1->0 transition
//   STABLE   out  1 when no line has a change pending
module dig_input_conditioner #(
    parameter int               WIDTH      = 5,
    parameter int               DEB_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] RAW_IN,
    input  logic             HOLD,
    output logic [WIDTH-1:0] COND_OUT,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL,
    output logic             STABLE
);

    localparam int               CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
`ifdef DIG_COND_SYNC3_EN
    logic [WIDTH-1:0] s3_q, s3_d;
`endif
    logic [WIDTH-1:0] s_sync;

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            cond_q, cond_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic                        stable_q, stable_d;

    // Synchroniser chain: never gated by HOLD so the view of RAW_IN stays current.
    always_comb begin
        s1_d = RAW_IN;
        s2_d = s1_q;
`ifdef DIG_COND_SYNC3_EN
        s3_d   = s2_q;
        s_sync = s3_q;
`else
        s_sync = s2_q;
`endif
    end

    // Per-bit debounce. A counter only runs while the synchronised level
    // differs from the accepted level, and it saturates at CNT_MAX: the
    // edge that finds it at CNT_MAX with the difference still present is
    // the acceptance edge.
    always_comb begin
        cnt_d    = cnt_q;
        cond_d   = cond_q;
        rise_d   = '0;
        fall_d   = '0;
        stable_d = stable_q;
        if (!HOLD) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s_sync[i] == cond_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    cond_d[i] = s_sync[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = s_sync[i];
                    fall_d[i] = ~s_sync[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // Uses next-state counters and outputs so STABLE rises on the
            // same edge that accepts or abandons the last pending change.
            stable_d = (cnt_d == '0) && (s_sync == cond_d);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q     <= RESET_VAL;
            s2_q     <= RESET_VAL;
`ifdef DIG_COND_SYNC3_EN
            s3_q     <= RESET_VAL;
`endif
            cnt_q    <= '0;
            cond_q   <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            stable_q <= 1'b1;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
`ifdef DIG_COND_SYNC3_EN
            s3_q     <= s3_d;
`endif
            cnt_q    <= cnt_d;
            cond_q   <= cond_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            stable_q <= stable_d;
        end
    end

    assign COND_OUT = cond_q;
    assign RISE     = rise_q;
    assign FALL     = fall_q;
    assign STABLE   = stable_q;

endmodule

// File: tb/tb_dig_input_conditioner.sv
// Self-checking bench for dig_input_conditioner.
// Two instances: dut_a (DEB_CYCLES=4) and dut_b (DEB_CYCLES=8), each with
// its own reset, HOLD and RAW_IN. Expected RISE/FALL events, with the cycle
// on which they must appear, are queued when stimulus is applied and
// compared by a per-instance monitor whenever an event is observed.
module tb_dig_input_conditioner;

`ifdef DIG_COND_SYNC3_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif
    localparam int DEB_A = 4;
    localparam int DEB_B = 8;
    localparam int LAT_A = DEB_A + 2 + S;
    localparam int LAT_B = DEB_B + 2 + S;

    logic       clk = 1'b0;
    logic       rst_a_n = 1'b0;
    logic       rst_b_n = 1'b0;
    logic       hold_a = 1'b0;
    logic       hold_b = 1'b0;
    logic [4:0] raw_a = 5'b0;
    logic [4:0] raw_b = 5'b0;
    logic [4:0] cond_a, rise_a, fall_a;
    logic [4:0] cond_b, rise_b, fall_b;
    logic       stable_a, stable_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [4:0] rise;
        logic [4:0] fall;
        logic [4:0] cond;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    ev_t ea, eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dig_input_conditioner #(.WIDTH(5), .DEB_CYCLES(DEB_A), .RESET_VAL(5'b00000)) dut_a (
        .CLK(clk), .RST_N(rst_a_n), .RAW_IN(raw_a), .HOLD(hold_a),
        .COND_OUT(cond_a), .RISE(rise_a), .FALL(fall_a), .STABLE(stable_a));

    dig_input_conditioner #(.WIDTH(5), .DEB_CYCLES(DEB_B), .RESET_VAL(5'b00000)) dut_b (
        .CLK(clk), .RST_N(rst_b_n), .RAW_IN(raw_b), .HOLD(hold_b),
        .COND_OUT(cond_b), .RISE(rise_b), .FALL(fall_b), .STABLE(stable_b));

    // Monitors: every observed event must match the head of the queue.
    always @(negedge clk) begin
        if ((rise_a | fall_a) !== 5'b0) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL mon_a unexpected event cyc=%0d rise=%b fall=%b", cyc, rise_a, fall_a);
            end else begin
                ea = q_a.pop_front();
                if (cyc !== ea.cyc || rise_a !== ea.rise || fall_a !== ea.fall || cond_a !== ea.cond) begin
                    errors++;
                    $display("FAIL mon_a event got cyc=%0d rise=%b fall=%b cond=%b exp cyc=%0d rise=%b fall=%b cond=%b",
                             cyc, rise_a, fall_a, cond_a, ea.cyc, ea.rise, ea.fall, ea.cond);
                end
            end
        end
    end

    always @(negedge clk) begin
        if ((rise_b | fall_b) !== 5'b0) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL mon_b unexpected event cyc=%0d rise=%b fall=%b", cyc, rise_b, fall_b);
            end else begin
                eb = q_b.pop_front();
                if (cyc !== eb.cyc || rise_b !== eb.rise || fall_b !== eb.fall || cond_b !== eb.cond) begin
                    errors++;
                    $display("FAIL mon_b event got cyc=%0d rise=%b fall=%b cond=%b exp cyc=%0d rise=%b fall=%b cond=%b",
                             cyc, rise_b, fall_b, cond_b, eb.cyc, eb.rise, eb.fall, eb.cond);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int c, input logic [4:0] r, input logic [4:0] f, input logic [4:0] cd);
        ev_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.cond = cd;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int c, input logic [4:0] r, input logic [4:0] f, input logic [4:0] cd);
        ev_t e;
        e.cyc = c; e.rise = r; e.fall = f; e.cond = cd;
        q_b.push_back(e);
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        raw_a   = 5'b10101;
        repeat (3) tick();
        checks++;
        if (cond_a !== 5'b0) begin errors++; $display("FAIL reset_cond got=%b exp=%b", cond_a, 5'b0); end
        checks++;
        if (rise_a !== 5'b0 || fall_a !== 5'b0) begin errors++; $display("FAIL reset_events got rise=%b fall=%b exp 0", rise_a, fall_a); end
        checks++;
        if (stable_a !== 1'b1) begin errors++; $display("FAIL reset_stable got=%b exp=1", stable_a); end
        checks++;
        if (stable_b !== 1'b1 || cond_b !== 5'b0) begin errors++; $display("FAIL reset_b got stable=%b cond=%b exp 1/00000", stable_b, cond_b); end
        // Release with RAW_IN != RESET_VAL: only a full debounce may produce an event.
        push_a(cyc + LAT_A, 5'b10101, 5'b0, 5'b10101);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (LAT_A + 3) tick();
        checks++;
        if (cond_a !== 5'b10101) begin errors++; $display("FAIL reset_release_cond got=%b exp=%b", cond_a, 5'b10101); end
        raw_a = 5'b0;
        push_a(cyc + LAT_A, 5'b0, 5'b10101, 5'b0);
        repeat (LAT_A + 3) tick();
        checks++;
        if (cond_a !== 5'b0 || stable_a !== 1'b1) begin errors++; $display("FAIL reset_return got cond=%b stable=%b exp 00000/1", cond_a, stable_a); end
    endtask

    task automatic test_latency();
        int   c;
        logic exp_st;
        raw_a[0] = 1'b1;
        c = cyc;
        push_a(c + LAT_A, 5'b00001, 5'b0, 5'b00001);
        for (int j = 1; j <= LAT_A + 1; j++) begin
            tick();
            exp_st = (j >= 3 + S && j <= DEB_A + 1 + S) ? 1'b0 : 1'b1;
            checks++;
            if (stable_a !== exp_st) begin errors++; $display("FAIL latency_stable j=%0d got=%b exp=%b", j, stable_a, exp_st); end
            if (j == LAT_A - 1) begin
                checks++;
                if (cond_a[0] !== 1'b0) begin errors++; $display("FAIL latency_early got=%b exp=0", cond_a[0]); end
            end
            if (j == LAT_A) begin
                checks++;
                if (cond_a[0] !== 1'b1) begin errors++; $display("FAIL latency_cond got=%b exp=1", cond_a[0]); end
            end
        end
        raw_a[0] = 1'b0;
        push_a(cyc + LAT_A, 5'b0, 5'b00001, 5'b0);
        repeat (LAT_A + 3) tick();
    endtask

    task automatic test_glitch();
        // DEB_CYCLES-1 wide pulse: rejected.
        raw_a[2] = 1'b1;
        repeat (DEB_A - 1) tick();
        raw_a[2] = 1'b0;
        repeat (LAT_A + 4) tick();
        checks++;
        if (cond_a !== 5'b0) begin errors++; $display("FAIL glitch_short got=%b exp=%b", cond_a, 5'b0); end
        // DEB_CYCLES wide pulse: accepted, then falls after its own debounce.
        raw_a[2] = 1'b1;
        push_a(cyc + LAT_A, 5'b00100, 5'b0, 5'b00100);
        repeat (DEB_A) tick();
        raw_a[2] = 1'b0;
        push_a(cyc + LAT_A, 5'b0, 5'b00100, 5'b0);
        repeat (LAT_A + 4) tick();
        checks++;
        if (cond_a !== 5'b0) begin errors++; $display("FAIL glitch_long_end got=%b exp=%b", cond_a, 5'b0); end
    endtask

    task automatic test_simultaneous();
        raw_a = 5'b11111;
        push_a(cyc + LAT_A, 5'b11111, 5'b0, 5'b11111);
        repeat (LAT_A + 3) tick();
        checks++;
        if (cond_a !== 5'b11111) begin errors++; $display("FAIL simul_cond got=%b exp=%b", cond_a, 5'b11111); end
        raw_a = 5'b0;
        push_a(cyc + LAT_A, 5'b0, 5'b11111, 5'b0);
        repeat (LAT_A + 3) tick();
        checks++;
        if (cond_a !== 5'b0) begin errors++; $display("FAIL simul_fall_cond got=%b exp=%b", cond_a, 5'b0); end
    endtask

    task automatic test_hold();
        raw_b[1] = 1'b1;
        push_b(cyc + LAT_B + 10, 5'b00010, 5'b0, 5'b00010);
        repeat (5 + S) tick();   // counter now at 3
        hold_b = 1'b1;
        repeat (10) tick();
        checks++;
        if (stable_b !== 1'b0 || cond_b !== 5'b0) begin errors++; $display("FAIL hold_frozen got stable=%b cond=%b exp 0/00000", stable_b, cond_b); end
        hold_b = 1'b0;
        repeat (LAT_B + 3) tick();
        checks++;
        if (cond_b !== 5'b00010) begin errors++; $display("FAIL hold_cond got=%b exp=%b", cond_b, 5'b00010); end
    endtask

    task automatic test_reset_mid();
        raw_b[3] = 1'b1;
        repeat (8 + S) tick();   // counter now at 6
        rst_b_n = 1'b0;
        #1;
        checks++;
        if (cond_b !== 5'b0) begin errors++; $display("FAIL rstmid_cond got=%b exp=%b", cond_b, 5'b0); end
        checks++;
        if (stable_b !== 1'b1 || rise_b !== 5'b0) begin errors++; $display("FAIL rstmid_state got stable=%b rise=%b exp 1/00000", stable_b, rise_b); end
        tick();
        tick();
        push_b(cyc + LAT_B, 5'b01010, 5'b0, 5'b01010);
        rst_b_n = 1'b1;
        repeat (LAT_B + 3) tick();
        checks++;
        if (cond_b !== 5'b01010) begin errors++; $display("FAIL rstmid_after got=%b exp=%b", cond_b, 5'b01010); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_hold();
        test_reset_mid();
        repeat (2) tick();
        checks++;
        if (q_a.size() != 0) begin errors++; $display("FAIL missing_events_a got=%0d pending exp=0", q_a.size()); end
        checks++;
        if (q_b.size() != 0) begin errors++; $display("FAIL missing_events_b got=%0d pending exp=0", q_b.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d exp finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dig_input_conditioner.md
# dig_input_conditioner

- Upstream front end for the `DigCt` logic stage.
- Takes five raw, asynchronous input lines and delivers clean versions on `COND_OUT[4:0]`, which drive `IN1`..`IN5` of `DigCt`. Each line is synchronised and then debounced.
- Also flags each accepted transition with a one-cycle `RISE`/`FALL` pulse, and reports when no line has a change pending.

## Interface
Parameters:
- `WIDTH`, default 5: number of conditioned lines; bit i drives `DigCt` input IN(i+1).
- `DEB_CYCLES`, default 16: number of consecutive clock edges a new synchronised level must hold before it is accepted. Legal range is 2..255.
- `RESET_VAL`, default 5'b00000: value loaded into the sync stages and `COND_OUT` on reset.

Ports:
- `CLK`, input, 1: single clock, rising-edge. Same clock as `DigCt`.
- `RST_N`, input, 1: reset, asynchronous, active-low.
- `RAW_IN`, input, WIDTH: raw lines, asynchronous to `CLK`.
- `HOLD`, input, 1: when 1, freezes the debounce counters, `COND_OUT` and `STABLE`. The sync stages keep sampling.
- `COND_OUT`, output, WIDTH: debounced, registered levels.
- `RISE`, output, WIDTH: one-cycle pulse when `COND_OUT[i]` goes 0→1.
- `FALL`, output, WIDTH: one-cycle pulse when `COND_OUT[i]` goes 1→0.
- `STABLE`, output, 1: registered; 1 when every counter is 0 and no change is pending.

## Operation
- Sync chain, per bit: `RAW_IN` → `s1` → `s2`. The synchronised level is `s = s2`.
- Counters are per bit, with width `CNT_W = $clog2(DEB_CYCLES)`. They never wrap: the maximum value reached is `DEB_CYCLES-1`.
- Per bit, on each rising edge with `HOLD`=0:
  - `s == COND_OUT[i]`: `cnt <= 0`. No event.
  - `s != COND_OUT[i]` and `cnt < DEB_CYCLES-1`: `cnt <= cnt+1`.
  - `s != COND_OUT[i]` and `cnt == DEB_CYCLES-1`: `COND_OUT[i] <= s`, `cnt <= 0`. Pulse `RISE[i]` or `FALL[i]` on the same edge.
- `RISE` and `FALL` are 0 on every edge not listed above, including every edge with `HOLD`=1.
- `STABLE <= 1` exactly when all next-state counters are 0 and all `s == COND_OUT` (next-state).
- Bits are fully independent. Simultaneous acceptances on several bits all pulse in the same cycle.
- `HOLD`=1 mid-count: the count is preserved and resumes when `HOLD` drops. If `s` reverts while held, the first unheld edge clears the counter.
- Reset values:
  - `s1`, `s2`, `COND_OUT` = `RESET_VAL`.
  - `cnt` = 0.
  - `RISE` = `FALL` = 0.
  - `STABLE` = 1.
- Reset asserted mid-count discards all pending counts immediately. No event is generated on release, even if `RAW_IN` differs from `RESET_VAL`; the normal debounce applies from the first edge after release.

## Timing
- Let edge 0 be the first edge at which `s1` samples a new stable `RAW_IN` level.
- `s2` changes at edge 1.
- Counting runs on edges 2..DEB_CYCLES.
- `COND_OUT` and `RISE`/`FALL` update at edge `DEB_CYCLES+1`. Raw-to-output latency is `DEB_CYCLES+2` edges, deterministic, with `HOLD`=0.
- Glitch filtering, measured at `s`:
  - A pulse lasting `DEB_CYCLES` edges is accepted.
  - A pulse lasting `DEB_CYCLES-1` edges or fewer is rejected: no output change, no event.
- `STABLE` falls at edge 2 and returns to 1 on the acceptance edge, or on the edge where `s` reverts.
- `RISE` and `FALL` are never both 1 on the same bit.
- `COND_OUT` feeds `DigCt` combinationally. `DigCt` registers its outputs one edge after `COND_OUT` changes.

## Configuration
- Macro: `DIG_COND_SYNC3_EN`.
- Defined: a third sync stage `s3` is added, reset to `RESET_VAL`, and `s = s3`. Every latency above grows by 1: acceptance occurs at edge `DEB_CYCLES+2`.
- Undefined: two-stage chain as specified above.
- Debounce rules, `HOLD` and reset behaviour are identical in both builds.

## Test plan
- **Reset state.** `RST_N`=0 with `RAW_IN`=5'b10101 and `RESET_VAL`=0 → `COND_OUT`=0, `RISE`=`FALL`=0, `STABLE`=1. Release reset: no event until bit 0 has completed a full debounce.
- **Latency.** `DEB_CYCLES`=4, `RAW_IN[0]` 0→1 before edge 0 → `COND_OUT[0]`=1 and `RISE[0]`=1 for exactly one cycle after edge 5. `STABLE`=0 after edges 2..4.
- **Glitch boundary.** `DEB_CYCLES`=4:
  - `RAW_IN[2]` high for 3 cycles → no change, no event.
  - `RAW_IN[2]` high for 4 cycles → `RISE[2]` pulses.
  - When it later drops, after the full debounce → `FALL[2]` pulses.
- **Simultaneous bits.** `RAW_IN` 5'b00000→5'b11111 on one edge → all five `RISE` bits pulse in the same cycle. `COND_OUT`=5'b11111.
- **HOLD and reset mid-operation.** `DEB_CYCLES`=8:
  - Assert `HOLD` for 10 cycles after count 3 → latency extends by exactly 10 cycles.
  - Separately, pull `RST_N` low at count 6 → `COND_OUT` returns to `RESET_VAL` immediately and the count restarts from 0.
- **Sync3 build.** `DIG_COND_SYNC3_EN` defined with `DEB_CYCLES`=4 → acceptance at edge 6. All other checks above pass, shifted by one cycle.
